// File: rtl/idu_hazard_ctrl.sv
// idu_hazard_ctrl: decode-stage issue control; scoreboards divider/load writebacks
// and stalls decode on RAW/WAW hazards, a busy divider or a full load window.
module idu_hazard_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int MAX_LD   = 2,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_dec_valid,
   input  logic                i_dec_rs1,
   input  logic [AW-1:0]       i_dec_rs1_addr,
   input  logic                i_dec_rs2,
   input  logic [AW-1:0]       i_dec_rs2_addr,
   input  logic                i_dec_rd,
   input  logic [AW-1:0]       i_dec_rd_addr,
   input  logic                i_dec_div,
   input  logic                i_dec_load,
   input  logic                i_div_wb_valid,
   input  logic [AW-1:0]       i_div_wb_addr,
   input  logic                i_ld_wb_valid,
   input  logic [AW-1:0]       i_ld_wb_addr,
   input  logic                i_pipe_flush,
   output logic                o_pipe_stall,
   output logic                o_issue,
   output logic                o_div_busy,
   output logic [NUM_REGS-1:0] o_sb_pend
);
   localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
   typedef enum logic {S_IDLE, S_BUSY} state_t;
   state_t              r_state;
   logic [NUM_REGS-1:0] r_sb;
   logic [2:0]          r_ld_cnt;
   logic [NUM_REGS-1:0] w_clr, w_set, w_sb_eff;
   logic                w_haz, w_ld_inc;
   // Writebacks landing this cycle forward to decode, so they mask their own sb bit.
   assign w_clr    = (i_div_wb_valid ? ONE << i_div_wb_addr : '0) |
                     (i_ld_wb_valid  ? ONE << i_ld_wb_addr  : '0);
   assign w_sb_eff = r_sb & ~w_clr;
   assign w_haz    = i_dec_valid & ((i_dec_rs1  & w_sb_eff[i_dec_rs1_addr]) |
                                    (i_dec_rs2  & w_sb_eff[i_dec_rs2_addr]) |
                                    (i_dec_rd   & w_sb_eff[i_dec_rd_addr])  |
                                    (i_dec_div  & o_div_busy)               |
                                    (i_dec_load & (r_ld_cnt == 3'(MAX_LD))));
   assign o_pipe_stall = i_rstn & w_haz & ~i_pipe_flush;
   assign o_issue      = i_rstn & i_dec_valid & ~w_haz & ~i_pipe_flush;
   assign w_set        = (o_issue & i_dec_rd & (i_dec_div | i_dec_load)) ? ONE << i_dec_rd_addr : '0;
   assign w_ld_inc     = o_issue & i_dec_load;
   assign o_div_busy   = r_state == S_BUSY;
   assign o_sb_pend    = r_sb;
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state  <= S_IDLE;
         r_sb     <= '0;
         r_ld_cnt <= '0;
      end else begin
         r_state  <= (r_state == S_IDLE && o_issue && i_dec_div) ? S_BUSY :
                     (r_state == S_BUSY && i_div_wb_valid)       ? S_IDLE : r_state;
         r_sb     <= ((r_sb & ~w_clr) | w_set) & ~ONE;
         r_ld_cnt <= (w_ld_inc & ~i_ld_wb_valid) ? r_ld_cnt + 3'd1 :
                     (i_ld_wb_valid & ~w_ld_inc & (r_ld_cnt != 3'd0)) ? r_ld_cnt - 3'd1 : r_ld_cnt;
      end
   end
   a_ld_underflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
      !(i_ld_wb_valid && r_ld_cnt == 3'd0));
endmodule
